conv_window_gen: RTL
====================

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter IMG_WIDTH, default 4, pixels per row; the legal range is 2..256.
REQ-002 Parameter IMG_HEIGHT, default 4, rows per frame; the legal range is 2..256.
REQ-003 Port clk  input  1  single clock; all logic is rising-edge.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port in_pixel  input  8  raster-order pixel, unsigned.
REQ-006 Port in_valid  input  1  in_pixel is valid this cycle.
REQ-007 Port in_sof  input  1  start of frame; qualified by in_valid.
REQ-008 Port in_ready  output  1  the block accepts a pixel this cycle.
REQ-009 Port pixels  output  4x8 (packed [3:0][7:0])  2x2 window: [3]=top-left, [2]=top-right, [1]=bottom-left, [0]=bottom-right; drives the downstream convolution neuron.
REQ-010 Port out_valid  output  1  pixels holds a valid window.
REQ-011 Port out_ready  input  1  downstream consumes the window.
REQ-012 Port frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-013 A pixel is accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-014 in_ready = !out_valid || out_ready (combinational, no bubble when the output is drained).
REQ-015 Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) address the accepted pixel; both advance only on acceptance.
REQ-016 col wraps to 0 after IMG_WIDTH-1 and increments row; row wraps to 0 after IMG_HEIGHT-1.
REQ-017 Line buffer: IMG_WIDTH x 8-bit entries holding the previous row; entry[col] is read, then overwritten with the accepted pixel in the same acceptance cycle.
REQ-018 Registers left_cur (previous pixel, current row) and left_up (previous-row pixel at col-1) are updated on every acceptance.
REQ-019 Window on accepting pixel P at (row,col): {[3]=left_up, [2]=linebuf[col], [1]=left_cur, [0]=P}.
REQ-020 Stride 1: a window is produced for every accepted pixel with row>=1 and col>=1 (macro absent); this gives (IMG_WIDTH-1)*(IMG_HEIGHT-1) windows per frame.
REQ-021 Latency: pixels and out_valid update on the clock edge that accepts the producing pixel, so they are visible in the next cycle.
REQ-022 If out_valid=1 and out_ready=0, pixels and out_valid hold stable and no pixel is accepted.
REQ-023 If out_valid=1 and out_ready=1 and an accepted pixel produces no window, out_valid clears to 0.
REQ-024 If out_valid=1, out_ready=1, and the accepted pixel produces a window, the new window loads and out_valid stays 1 (back-to-back throughput, one window per cycle).
REQ-025 An accepted pixel with in_sof=1 is forced to (row=0,col=0) regardless of the counter state; the counters then continue from (0,1), and the partial previous frame is abandoned without raising frame_done.
REQ-026 frame_done pulses for exactly one cycle, in the cycle after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
REQ-027 in_sof is ignored when in_valid=0.

Reset
REQ-028 On rst=1: row=0, col=0, out_valid=0, pixels=0, frame_done=0, left_cur=0, left_up=0.
REQ-029 Line buffer contents are not reset; they are never exposed before being rewritten, because row 0 produces no window (or produces padded zeros under the macro).
REQ-030 rst mid-frame discards any pending output window; the first pixel accepted after reset is treated as (0,0).
REQ-031 in_ready = 1 in the first cycle after reset is released.

Configuration
REQ-032 Macro WINGEN_ZERO_PAD_EN: when defined, every accepted pixel produces a window (IMG_WIDTH*IMG_HEIGHT per frame), and neighbours lying in row -1 or col -1 are replaced with 8'h00.
REQ-033 When WINGEN_ZERO_PAD_EN is undefined, REQ-020 applies and no padding logic is synthesized.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, out_ready=1 unless stated)
REQ-034 Stream 12 pixels 8'h01..8'h0C, with in_sof on the first -> 6 windows; the first window is {01,02,05,06}, the last is {07,08,0B,0C}; frame_done pulses once, one cycle after 8'h0C is accepted.
REQ-035 Same stream with out_ready=0 for 5 cycles after the first window -> pixels holds {01,02,05,06}, in_ready=0 throughout, and no window is lost or duplicated.
REQ-036 Pulse in_sof on the 7th pixel -> counters restart, no frame_done is raised, and the first window after the restart appears on the 6th pixel after the sof.
REQ-037 Assert rst after the 9th pixel -> out_valid=0 and pixels=0 in the next cycle; a fresh 12-pixel frame then reproduces REQ-034 exactly.
REQ-038 Apply in_valid gaps (alternating 1/0) -> identical window sequence to REQ-034.
REQ-039 With WINGEN_ZERO_PAD_EN defined, run the REQ-034 stream -> 12 windows; the first is {00,00,00,01}, the fifth is {00,01,00,05}.

Source files
------------

// File: rtl/conv_window_gen.sv
// conv_window_gen: streams raster-order 8-bit pixels and emits 2x2 windows
// (stride 1) for a downstream convolution neuron.
//
// Optional feature macro: WINGEN_ZERO_PAD_EN
//   undefined : a window is emitted only for pixels at row>=1 and col>=1
//   defined   : every pixel emits a window; neighbours in row -1 / col -1
//               read as 8'h00
//
// Window packing: [3]=top-left, [2]=top-right, [1]=bottom-left,
// [0]=bottom-right (the pixel just accepted).
module conv_window_gen #(
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      in_pixel,
    input  logic            in_valid,
    input  logic            in_sof,
    output logic            in_ready,
    output logic [3:0][7:0] pixels,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            frame_done
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [7:0]      left_cur_q, left_cur_d;
    logic [7:0]      left_up_q, left_up_d;
    logic [3:0][7:0] pixels_q, pixels_d;
    logic            out_valid_q, out_valid_d;
    logic            frame_done_q, frame_done_d;

    // Previous-row storage; never reset because row 0 always rewrites an
    // entry before the row below can read it.
    logic [7:0]      linebuf_q [IMG_WIDTH];

    logic            accept;
    logic [CW-1:0]   pos_col;
    logic [RW-1:0]   pos_row;
    logic [7:0]      lb_rd;
    logic            at_col_last;
    logic            at_row_last;
    logic            win_hit;
    logic [3:0][7:0] win_data;

    // Downstream backpressure gates intake; no bubble when the window drains.
    assign in_ready   = !out_valid_q || out_ready;

    assign pixels     = pixels_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

    // Position of the pixel on the input this cycle and the window it forms.
    always_comb begin
        accept      = in_valid && in_ready;
        // A start-of-frame pixel is pinned to (0,0) whatever the counters say.
        pos_col     = in_sof ? '0 : col_q;
        pos_row     = in_sof ? '0 : row_q;
        lb_rd       = linebuf_q[pos_col];
        at_col_last = (pos_col == COL_LAST);
        at_row_last = (pos_row == ROW_LAST);
`ifdef WINGEN_ZERO_PAD_EN
        win_hit     = 1'b1;
        win_data[3] = ((pos_row == '0) || (pos_col == '0)) ? 8'h00 : left_up_q;
        win_data[2] = (pos_row == '0) ? 8'h00 : lb_rd;
        win_data[1] = (pos_col == '0) ? 8'h00 : left_cur_q;
        win_data[0] = in_pixel;
`else
        win_hit     = (pos_row != '0) && (pos_col != '0);
        win_data[3] = left_up_q;
        win_data[2] = lb_rd;
        win_data[1] = left_cur_q;
        win_data[0] = in_pixel;
`endif
    end

    // Next-state: raster counters, left-neighbour registers, output window.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        left_cur_d   = left_cur_q;
        left_up_d    = left_up_q;
        pixels_d     = pixels_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;

        if (accept) begin
            left_cur_d   = in_pixel;
            left_up_d    = lb_rd;
            frame_done_d = at_col_last && at_row_last;

            if (at_col_last) begin
                col_d = '0;
                row_d = at_row_last ? '0 : pos_row + RW'(1);
            end else begin
                col_d = pos_col + CW'(1);
                row_d = pos_row;
            end

            // A pixel that forms no window still retires the drained one.
            out_valid_d = win_hit;
            if (win_hit) begin
                pixels_d = win_data;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            left_cur_q   <= '0;
            left_up_q    <= '0;
            pixels_q     <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            left_cur_q   <= left_cur_d;
            left_up_q    <= left_up_d;
            pixels_q     <= pixels_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer: read old entry (above) and overwrite it in the same cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf_q[pos_col] <= in_pixel;
        end
    end

endmodule
